// File: rtl/axi_lite_data_ram.sv
// rtl/axi_lite_data_ram.sv - AXI4-lite slave word RAM with byte-strobe writes and SLVERR outside the window
//
// Purpose: data memory behind the core's AXI4-lite load/store port. Independent
// read and write channels, one outstanding transaction per direction.
//
// Ports:
//   i_clk, i_rst_n           clock; synchronous reset, active high (asserted when 1)
//   AW channel               i_axi_awvalid, o_axi_awready, i_axi_awaddr, i_axi_awprot (ignored)
//   W channel                i_axi_wvalid, o_axi_wready, i_axi_wdata, i_axi_wstrb
//   B channel                o_axi_bvalid, i_axi_bready, o_axi_bresp
//   AR channel               i_axi_arvalid, o_axi_arready, i_axi_araddr, i_axi_arprot (ignored)
//   R channel                o_axi_rvalid, i_axi_rready, o_axi_rdata, o_axi_rresp

module axi_lite_data_ram #(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_axi_awvalid,
  output logic        o_axi_awready,
  input  logic [31:0] i_axi_awaddr,
  input  logic [2:0]  i_axi_awprot,
  input  logic        i_axi_wvalid,
  output logic        o_axi_wready,
  input  logic [31:0] i_axi_wdata,
  input  logic [3:0]  i_axi_wstrb,
  output logic        o_axi_bvalid,
  input  logic        i_axi_bready,
  output logic [1:0]  o_axi_bresp,
  input  logic        i_axi_arvalid,
  output logic        o_axi_arready,
  input  logic [31:0] i_axi_araddr,
  input  logic [2:0]  i_axi_arprot,
  output logic        o_axi_rvalid,
  input  logic        i_axi_rready,
  output logic [31:0] o_axi_rdata,
  output logic [1:0]  o_axi_rresp
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int         DEPTH       = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_COMMIT = 2'd1,
    W_RESP   = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  w_state_e r_wstate;
  w_state_e w_wstate_nx;
  r_state_e r_rstate;
  r_state_e w_rstate_nx;

  // Keeps all readies low for the cycle following a reset edge.
  logic r_en;

  logic                  r_aw_full;
  logic                  r_aw_in;
  logic [ADDR_WIDTH-1:0] r_aw_idx;
  logic                  r_w_full;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wstrb;
  logic [1:0]            r_bresp;

  logic                  r_rd_ok;
  logic [1:0]            r_rresp;
  logic [31:0]           r_rd_word;

  logic [31:0]           r_mem [DEPTH];

  logic [31:0] w_aw_off;
  logic [31:0] w_ar_off;
  logic        w_aw_in;
  logic        w_ar_in;
  logic        w_awready;
  logic        w_wready;
  logic        w_bvalid;
  logic        w_commit;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_arready;
  logic        w_rvalid;
  logic        w_ar_hs;
  logic        w_mem_we;
  logic        w_unused_ok;

  // Offset from the window base wraps in 32 bits; anything above the window
  // (including addresses below the base, which wrap to large offsets) is out.
  assign w_aw_off = i_axi_awaddr - BASE_ADDR;
  assign w_ar_off = i_axi_araddr - BASE_ADDR;
  assign w_aw_in  = (w_aw_off[31:ADDR_WIDTH+2] == '0);
  assign w_ar_in  = (w_ar_off[31:ADDR_WIDTH+2] == '0);

  assign w_unused_ok = ^{i_axi_awprot, i_axi_arprot, w_aw_off[1:0], w_ar_off[1:0]};

  always_ff @(posedge i_clk) begin
    if (i_rst_n) r_en <= 1'b0;
    else         r_en <= 1'b1;
  end

  // ---------------- write path ----------------
  always_ff @(posedge i_clk) begin
    if (i_rst_n) r_wstate <= W_IDLE;
    else         r_wstate <= w_wstate_nx;
  end

  always_comb begin
    w_wstate_nx = r_wstate;
    w_awready   = 1'b0;
    w_wready    = 1'b0;
    w_bvalid    = 1'b0;
    w_commit    = 1'b0;
    w_aw_hs     = 1'b0;
    w_w_hs      = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        w_awready = r_en & ~r_aw_full;
        w_wready  = r_en & ~r_w_full;
        w_aw_hs   = i_axi_awvalid & w_awready;
        w_w_hs    = i_axi_wvalid & w_wready;
        if ((r_aw_full | w_aw_hs) & (r_w_full | w_w_hs)) w_wstate_nx = W_COMMIT;
      end
      W_COMMIT: begin
        w_commit    = 1'b1;
        w_wstate_nx = W_RESP;
      end
      W_RESP: begin
        w_bvalid = 1'b1;
        if (i_axi_bready) w_wstate_nx = W_IDLE;
      end
      default: w_wstate_nx = W_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      r_aw_full <= 1'b0;
      r_aw_in   <= 1'b0;
      r_aw_idx  <= '0;
      r_w_full  <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bresp   <= RESP_OKAY;
    end else if (w_commit) begin
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
      r_bresp   <= r_aw_in ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (w_aw_hs) begin
        r_aw_full <= 1'b1;
        r_aw_in   <= w_aw_in;
        r_aw_idx  <= w_aw_off[ADDR_WIDTH+1:2];
      end
      if (w_w_hs) begin
        r_w_full <= 1'b1;
        r_wdata  <= i_axi_wdata;
        r_wstrb  <= i_axi_wstrb;
      end
    end
  end

  // A commit coinciding with a reset edge must not touch the array.
  assign w_mem_we = w_commit & r_aw_in & ~i_rst_n;

  // Array and registered read port share one block without reset. Non-blocking
  // assignment gives read-before-write when both hit the same word.
  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (r_wstrb[b]) r_mem[r_aw_idx][8*b +: 8] <= r_wdata[8*b +: 8];
      end
    end
    if (w_ar_hs) r_rd_word <= r_mem[w_ar_off[ADDR_WIDTH+1:2]];
  end

  // ---------------- read path ----------------
  always_ff @(posedge i_clk) begin
    if (i_rst_n) r_rstate <= R_IDLE;
    else         r_rstate <= w_rstate_nx;
  end

  always_comb begin
    w_rstate_nx = r_rstate;
    w_arready   = 1'b0;
    w_rvalid    = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        w_arready = r_en;
        if (i_axi_arvalid & r_en) w_rstate_nx = R_DATA;
      end
      R_DATA: begin
        w_rvalid = 1'b1;
        if (i_axi_rready) w_rstate_nx = R_IDLE;
      end
      default: w_rstate_nx = R_IDLE;
    endcase
  end

  assign w_ar_hs = i_axi_arvalid & w_arready;

  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      r_rd_ok <= 1'b0;
      r_rresp <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rd_ok <= w_ar_in;
      r_rresp <= w_ar_in ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Out-of-window reads (and the post-reset state) return zero data.
  assign o_axi_rdata   = r_rd_ok ? r_rd_word : 32'h0;
  assign o_axi_rresp   = r_rresp;
  assign o_axi_rvalid  = w_rvalid;
  assign o_axi_arready = w_arready;
  assign o_axi_awready = w_awready;
  assign o_axi_wready  = w_wready;
  assign o_axi_bvalid  = w_bvalid;
  assign o_axi_bresp   = r_bresp;

endmodule

// File: doc/axi_lite_data_ram.md
# axi_lite_data_ram

AXI4-lite slave data memory answering the core's load/store master port: a word-organised synchronous RAM with byte-strobe writes, independent read and write channels, and one outstanding transaction per direction. Sits between the CPU's AXI4-lite master port and the data address space. Out-of-window accesses complete with SLVERR.

## Interface
- ADDR_WIDTH, 12: word-address bits; capacity 2^ADDR_WIDTH words (default 16 KiB).
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be 4-byte aligned.

- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-high reset: asserted when 1.
- axi_awvalid / axi_awready  in / out  1  write-address handshake.
- axi_awaddr  in  32  byte address.
- axi_awprot  in  3  ignored.
- axi_wvalid / axi_wready  in / out  1  write-data handshake.
- axi_wdata  in  32  write data.
- axi_wstrb  in  4  byte enables; bit i enables wdata[8i+7:8i].
- axi_bvalid / axi_bready  out / in  1  write-response handshake.
- axi_bresp  out  2  2'b00 OKAY, 2'b10 SLVERR.
- axi_arvalid / axi_arready  in / out  1  read-address handshake.
- axi_araddr  in  32  byte address.
- axi_arprot  in  3  ignored.
- axi_rvalid / axi_rready  out / in  1  read-data handshake.
- axi_rdata  out  32  read data.
- axi_rresp  out  2  2'b00 OKAY, 2'b10 SLVERR.

## Operation
- Address decode: off = addr - BASE_ADDR (32-bit, wraps); in range iff off < 4·2^ADDR_WIDTH; word index = off[ADDR_WIDTH+1:2]; addr[1:0] ignored. No sub-word alignment checks; the master does byte/half extraction.
- Write FSM, states W_IDLE, W_COMMIT, W_RESP:
  - W_IDLE: AW and W captured independently into one-entry holding registers. axi_awready = !aw_full, axi_wready = !w_full. AW and W may arrive in either order, in the same cycle, or any number of cycles apart. When both are full (including simultaneous capture) -> W_COMMIT.
  - W_COMMIT (1 cycle): if in range, write bytes enabled by wstrb; bresp=OKAY. If out of range, no write; bresp=SLVERR. wstrb=0 writes nothing, OKAY. Clear holding regs; -> W_RESP with bvalid=1.
  - W_RESP: hold bvalid, bresp until bready; on handshake bvalid=0 -> W_IDLE. Both readies are 0 in W_COMMIT and W_RESP.
- Read FSM, states R_IDLE, R_DATA:
  - R_IDLE: axi_arready=1. On the AR handshake, RAM read using axi_araddr directly -> R_DATA.
  - R_DATA: rvalid=1. rdata = RAM word (in range, rresp OKAY) or 32'h0 (out of range, SLVERR). rdata/rresp held stable until rready. On handshake -> R_IDLE. arready=0.
- Read/write same-word collision in one cycle: read-before-write (read returns pre-write data).
- RAM contents are not initialised by reset.

## Timing
- Reset values (while rst_n=1 and the cycle after): awready=0, wready=0, arready=0, bvalid=0, bresp=2'b00, rvalid=0, rresp=2'b00, rdata=0; FSMs in W_IDLE/R_IDLE; holding regs empty. Readies are 1 from the first cycle after rst_n falls.
- Reset mid-operation: uncommitted held AW/W discarded without a RAM write; pending B or R response dropped; RAM write in W_COMMIT on the reset edge is suppressed.
- Write: last of AW/W handshakes at edge k -> RAM updated at edge k+1 -> bvalid=1 after edge k+1. Best case is 3 cycles from handshake to next AW acceptance, with bready held 1.
- Read: AR handshake at edge k -> rvalid=1 after edge k. With rready=1, rvalid falls at edge k+1; next AR accepted at edge k+2. Max one read per 2 cycles.
- Ordering: an AR accepted at edge ≥ k+2 (any AR after B is observed) sees the new data; an AR at edge k+1 sees old data.
- Read and write paths are fully concurrent; no priority between them.

## Test plan
- Reset, then AW+W same cycle: addr 0x10, data 0xDEADBEEF, strb 4'hF -> bvalid one cycle later, bresp 00. Then AR 0x10 -> rdata 0xDEADBEEF, rresp 00, rvalid the cycle after AR.
- Byte strobes and order: W (0x11223344, strb 4'b0101) 3 cycles before AW 0x10 -> read 0x10 returns 0xDE22BE44. Same with AW first -> identical result.
- Backpressure: hold bready=0 and rready=0 for 5 cycles -> bvalid/bresp and rvalid/rdata stable; awready/wready/arready stay 0; responses complete on release.
- Out of range (default params): write 0x0000_4000 -> bresp 10, no RAM change; read 0x0000_4000 -> rdata 0, rresp 10; address 0x0000_3FFC -> OKAY.
- Collision: write 0xAAAA_AAAA to 0x20 (old value 0x5555_5555) with AR 0x20 accepted at the commit edge -> rdata 0x5555_5555; a following read -> 0xAAAA_AAAA.
- Reset mid-write: AW accepted and W pending, rst_n=1 for one cycle -> no bvalid; after reset, W alone produces no write until a new AW arrives; RAM word unchanged.
